bl_order_decode: RTL and testbench
==================================

Name: bl_order_decode

Overview:
- Receive-side companion to the X-engine baseline-order generator.
- Consumes the stream of antenna pairs (ant_a, ant_b, buf_sel, last_triangle) that accompanies X-engine accumulator output.
- For each pair it produces:
  - the canonical triangular baseline index;
  - conjugation and redundant-copy flags;
  - a frame-end marker.
- Independently regenerates the expected pair sequence and flags any mismatch, so downstream packetisers and accumulators can trust the index.

Parameters:
- N_ANTS, 16: antennas; power of two, >=4.
- ANT_BITS, log2(N_ANTS): antenna index width (localparam).
- BL_BITS, log2(N_ANTS*(N_ANTS+1)/2): baseline index width (localparam).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- sync  input  1  frame sync; restarts sequence tracking
- in_valid  input  1  pair on inputs is valid this cycle
- ant_a  input  ANT_BITS  antenna A of pair
- ant_b  input  ANT_BITS  antenna B of pair
- buf_sel  input  1  buffer select accompanying pair
- last_triangle  input  1  pair lies in lower triangle (a>b)
- bl_valid  output  1  outputs valid
- bl_idx  output  BL_BITS  canonical baseline index
- bl_conj  output  1  data must be conjugated (a>b)
- bl_redundant  output  1  duplicate baseline copy; downstream may drop
- bl_buf  output  1  buf_sel delayed to align
- bl_frame_end  output  1  pair (N-1,N-1), last of frame
- seq_err  output  1  sticky sequence-mismatch flag
- err_cnt  output  16  saturating mismatch count

Behaviour:
- Reset (rst_n=0, async): all outputs 0; pipeline valids 0; expected state loaded to the sync values below; err_cnt=0.

Latency:
- Fixed 3 cycles, in_valid -> bl_valid.
- All outputs registered and aligned with bl_valid.
- in_valid may toggle every cycle; there is no backpressure.

Index arithmetic:
- Stage 1:
  - lo=min(a,b), hi=max(a,b)
  - conj = (a>b)
  - redundant = (a>b) && (a-b == N_ANTS/2)
- Stage 2:
  - base = lo*N_ANTS (shift) − lo*(lo−1)/2, computed at 2*ANT_BITS width
  - d = hi−lo
- Stage 3: bl_idx = base + d, truncated to BL_BITS; the result is always < N(N+1)/2.

Sequence mirror:
- Expected state (ea, eb, eoff).
- On sync: ea=N/2, eb=0, eoff=N/2+1.
- On each in_valid:
  - if ea==eb: eb<=eb+1 (wrapping N−1 to 0), ea<=eoff, eoff<=eoff+1 (wrapping).
  - otherwise: ea<=ea+1 (wrapping).
- Frame period is N*(N/2+1) valid cycles.

Mismatch detection:
- Expected buffer bit eb_sel: cleared on sync; toggles after the pair with ea==eb==N−1 is consumed.
- Mismatch when in_valid and any of the following holds:
  - ant_a!=ea
  - ant_b!=eb
  - last_triangle!=(ea>eb)
  - buf_sel != (eb_sel ^ (ea>eb))
- On mismatch:
  - seq_err<=1; it clears only on sync or reset.
  - err_cnt increments, saturating at 0xFFFF; cleared on sync.
  - Mirror still advances from its expected values; it does not resync to the inputs.
- bl_frame_end = (ea==N−1 && eb==N−1) at input time, pipelined.

Boundary conditions:
- sync and in_valid in the same cycle: sync takes effect first; that pair is checked against (N/2, 0) and advances the mirror.
- sync does not flush the output pipeline; in-flight results still emerge.
- Reset mid-frame: pipeline is killed immediately; no bl_valid until new input.
- Wrap: after (N−1, N−1) the mirror returns to (N/2, 0) with eb_sel inverted.

Test Plan:
- N_ANTS=4, reset, sync, then 12 consecutive valid pairs from the generator sequence (2,0),(3,0),(0,0),(3,1),(0,1),(1,1),(0,2),(1,2),(2,2),(1,3),(2,3),(3,3) -> bl_idx = 2,3,0,6,1,4,2,5,7,6,8,9.
  - Required flags: conj on pairs 1,2,4; redundant on pairs 1,4; frame_end on pair 12 only.
  - bl_valid appears 3 cycles after each in_valid; seq_err stays 0.
- Same stream with in_valid gapped every other cycle -> identical outputs; bl_valid follows the same 3-cycle delay and pattern.
- Two full frames back to back: expected buf_sel is 0 for upper-triangle pairs of frame 1 and 1 for lower-triangle pairs; all polarities flip in frame 2; no errors.
- Corrupt the pair (0,1) to (0,2) -> seq_err=1, err_cnt=1, and subsequent correct pairs are not flagged. Assert sync -> seq_err=0 and err_cnt=0.
- Assert rst_n low mid-frame with three pairs in flight -> all outputs 0 asynchronously. After release and sync, the first pair (2,0) decodes to bl_idx=2.
- Feed 70000 corrupted pairs -> err_cnt saturates at 0xFFFF and does not wrap.

Source files
------------

// File: rtl/bl_order_decode.sv
// ---------------------------------------------------------------------------
// bl_order_decode
//
// Receive-side decoder for the antenna-pair stream that accompanies X-engine
// accumulator output. Each valid pair is turned into its canonical triangular
// baseline index, plus conjugate / redundant-copy / frame-end flags. In
// parallel, a mirror of the generator's pair ordering tracks what the next
// pair should be, and any disagreement is latched in seq_err / err_cnt.
//
// Stream protocol: in_valid qualifies ant_a/ant_b/buf_sel/last_triangle for
// exactly one cycle. There is no ready/backpressure; the block accepts every
// valid pair. bl_valid qualifies all bl_* outputs for exactly one cycle,
// three cycles after the matching in_valid.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   sync                  frame sync, restarts the sequence mirror
//   in_valid              input pair valid
//   ant_a, ant_b          antenna indices of the pair
//   buf_sel               buffer select travelling with the pair
//   last_triangle         pair lies in the lower triangle (a > b)
//   bl_valid              decoded outputs valid
//   bl_idx                canonical baseline index
//   bl_conj               data must be conjugated (a > b)
//   bl_redundant          duplicate baseline copy, may be dropped
//   bl_buf                buf_sel aligned with the outputs
//   bl_frame_end          this was pair (N-1, N-1)
//   seq_err               sticky sequence-mismatch flag
//   err_cnt               saturating mismatch count
// ---------------------------------------------------------------------------
module bl_order_decode #(
  parameter int N_ANTS = 16
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        sync,
  input  logic                                        in_valid,
  input  logic [$clog2(N_ANTS)-1:0]                   ant_a,
  input  logic [$clog2(N_ANTS)-1:0]                   ant_b,
  input  logic                                        buf_sel,
  input  logic                                        last_triangle,
  output logic                                        bl_valid,
  output logic [$clog2(N_ANTS*(N_ANTS+1)/2)-1:0]      bl_idx,
  output logic                                        bl_conj,
  output logic                                        bl_redundant,
  output logic                                        bl_buf,
  output logic                                        bl_frame_end,
  output logic                                        seq_err,
  output logic [15:0]                                 err_cnt
);

  localparam int ANT_BITS = $clog2(N_ANTS);
  localparam int BL_BITS  = $clog2(N_ANTS*(N_ANTS+1)/2);
  localparam int W2       = 2*ANT_BITS;

  localparam logic [ANT_BITS-1:0] HALF     = ANT_BITS'(N_ANTS/2);
  localparam logic [ANT_BITS-1:0] OFF_INIT = ANT_BITS'(N_ANTS/2 + 1);
  localparam logic [ANT_BITS-1:0] ANT_MAX  = ANT_BITS'(N_ANTS - 1);

  // -------------------------------------------------------------------------
  // Sequence mirror
  // -------------------------------------------------------------------------
  logic [ANT_BITS-1:0] ea_q, ea_d, eb_q, eb_d, eoff_q, eoff_d;
  logic                eb_sel_q, eb_sel_d;
  logic [ANT_BITS-1:0] cur_ea, cur_eb, cur_eoff;
  logic                cur_sel;
  logic                exp_lower;
  logic                mismatch;
  logic                seq_err_q, seq_err_d;
  logic [15:0]         err_cnt_q, err_cnt_d;
  logic                frame_end_in;

  always_comb begin
    // sync acts before the pair presented in the same cycle, so that pair is
    // checked against the restart values.
    cur_ea   = sync ? HALF     : ea_q;
    cur_eb   = sync ? '0       : eb_q;
    cur_eoff = sync ? OFF_INIT : eoff_q;
    cur_sel  = sync ? 1'b0     : eb_sel_q;

    exp_lower    = (cur_ea > cur_eb);
    frame_end_in = (cur_ea == ANT_MAX) && (cur_eb == ANT_MAX);

    mismatch = in_valid &&
               ((ant_a != cur_ea) ||
                (ant_b != cur_eb) ||
                (last_triangle != exp_lower) ||
                (buf_sel != (cur_sel ^ exp_lower)));

    ea_d     = cur_ea;
    eb_d     = cur_eb;
    eoff_d   = cur_eoff;
    eb_sel_d = cur_sel;
    // The mirror always advances from its own expected values; a bad input
    // never resynchronises it. Power-of-two N makes the wraps natural.
    if (in_valid) begin
      if (cur_ea == cur_eb) begin
        eb_d   = cur_eb + 1'b1;
        ea_d   = cur_eoff;
        eoff_d = cur_eoff + 1'b1;
        if (frame_end_in) eb_sel_d = ~cur_sel;
      end else begin
        ea_d = cur_ea + 1'b1;
      end
    end

    seq_err_d = sync ? 1'b0 : seq_err_q;
    err_cnt_d = sync ? 16'd0 : err_cnt_q;
    if (mismatch) begin
      seq_err_d = 1'b1;
      if (err_cnt_d != 16'hFFFF) err_cnt_d = err_cnt_d + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ea_q      <= HALF;
      eb_q      <= '0;
      eoff_q    <= OFF_INIT;
      eb_sel_q  <= 1'b0;
      seq_err_q <= 1'b0;
      err_cnt_q <= 16'd0;
    end else begin
      ea_q      <= ea_d;
      eb_q      <= eb_d;
      eoff_q    <= eoff_d;
      eb_sel_q  <= eb_sel_d;
      seq_err_q <= seq_err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // -------------------------------------------------------------------------
  // Stage 1: order the pair, derive flags
  // -------------------------------------------------------------------------
  logic                s1_valid_q, s1_valid_d;
  logic [ANT_BITS-1:0] s1_lo_q, s1_lo_d, s1_hi_q, s1_hi_d;
  logic                s1_conj_q, s1_conj_d, s1_red_q, s1_red_d;
  logic                s1_buf_q, s1_buf_d, s1_fe_q, s1_fe_d;
  logic                a_gt_b;
  logic [ANT_BITS-1:0] a_minus_b;

  always_comb begin
    a_gt_b     = (ant_a > ant_b);
    a_minus_b  = ant_a - ant_b;
    s1_valid_d = in_valid;
    s1_lo_d    = a_gt_b ? ant_b : ant_a;
    s1_hi_d    = a_gt_b ? ant_a : ant_b;
    s1_conj_d  = a_gt_b;
    // Half-way pairs appear twice in the generator order; the lower-triangle
    // copy is the duplicate.
    s1_red_d   = a_gt_b && (a_minus_b == HALF);
    s1_buf_d   = buf_sel;
    s1_fe_d    = frame_end_in;
  end

  // -------------------------------------------------------------------------
  // Stage 2: row base and column offset
  // -------------------------------------------------------------------------
  logic          s2_valid_q, s2_valid_d;
  logic [W2-1:0] s2_base_q, s2_base_d;
  logic [ANT_BITS-1:0] s2_d_q, s2_d_d;
  logic          s2_conj_q, s2_conj_d, s2_red_q, s2_red_d;
  logic          s2_buf_q, s2_buf_d, s2_fe_q, s2_fe_d;
  logic [W2-1:0] lo_w, tri_w;

  always_comb begin
    lo_w = W2'(s1_lo_q);
    // lo*(lo-1) is always even; for lo=0 the wrapped (lo-1) is multiplied by
    // zero, so the term vanishes as required.
    tri_w      = (lo_w * (lo_w - W2'(1))) >> 1;
    s2_valid_d = s1_valid_q;
    s2_base_d  = (lo_w << ANT_BITS) - tri_w;
    s2_d_d     = s1_hi_q - s1_lo_q;
    s2_conj_d  = s1_conj_q;
    s2_red_d   = s1_red_q;
    s2_buf_d   = s1_buf_q;
    s2_fe_d    = s1_fe_q;
  end

  // -------------------------------------------------------------------------
  // Stage 3: final index, output registers
  // -------------------------------------------------------------------------
  logic               o_valid_q, o_valid_d;
  logic [BL_BITS-1:0] o_idx_q, o_idx_d;
  logic               o_conj_q, o_conj_d, o_red_q, o_red_d;
  logic               o_buf_q, o_buf_d, o_fe_q, o_fe_d;

  always_comb begin
    o_valid_d = s2_valid_q;
    o_idx_d   = BL_BITS'(s2_base_q + W2'(s2_d_q));
    o_conj_d  = s2_conj_q;
    o_red_d   = s2_red_q;
    o_buf_d   = s2_buf_q;
    o_fe_d    = s2_fe_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_lo_q    <= '0;
      s1_hi_q    <= '0;
      s1_conj_q  <= 1'b0;
      s1_red_q   <= 1'b0;
      s1_buf_q   <= 1'b0;
      s1_fe_q    <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_base_q  <= '0;
      s2_d_q     <= '0;
      s2_conj_q  <= 1'b0;
      s2_red_q   <= 1'b0;
      s2_buf_q   <= 1'b0;
      s2_fe_q    <= 1'b0;
      o_valid_q  <= 1'b0;
      o_idx_q    <= '0;
      o_conj_q   <= 1'b0;
      o_red_q    <= 1'b0;
      o_buf_q    <= 1'b0;
      o_fe_q     <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_lo_q    <= s1_lo_d;
      s1_hi_q    <= s1_hi_d;
      s1_conj_q  <= s1_conj_d;
      s1_red_q   <= s1_red_d;
      s1_buf_q   <= s1_buf_d;
      s1_fe_q    <= s1_fe_d;
      s2_valid_q <= s2_valid_d;
      s2_base_q  <= s2_base_d;
      s2_d_q     <= s2_d_d;
      s2_conj_q  <= s2_conj_d;
      s2_red_q   <= s2_red_d;
      s2_buf_q   <= s2_buf_d;
      s2_fe_q    <= s2_fe_d;
      o_valid_q  <= o_valid_d;
      o_idx_q    <= o_idx_d;
      o_conj_q   <= o_conj_d;
      o_red_q    <= o_red_d;
      o_buf_q    <= o_buf_d;
      o_fe_q     <= o_fe_d;
    end
  end

  assign bl_valid     = o_valid_q;
  assign bl_idx       = o_idx_q;
  assign bl_conj      = o_conj_q;
  assign bl_redundant = o_red_q;
  assign bl_buf       = o_buf_q;
  assign bl_frame_end = o_fe_q;
  assign seq_err      = seq_err_q;
  assign err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_bl_order_decode.sv
// ---------------------------------------------------------------------------
// tb_bl_order_decode
//
// Bench for bl_order_decode at N_ANTS=4. Each driven pair pushes its expected
// decode (with the cycle it must appear in) to exp_q; a negedge monitor pops
// and compares whenever bl_valid is high. Status outputs are checked inline.
// ---------------------------------------------------------------------------
module tb_bl_order_decode;

  localparam int N  = 4;
  localparam int AB = 2;
  localparam int BB = 4;
  localparam int W  = 32 + BB + 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          sync;
  logic          in_valid;
  logic [AB-1:0] ant_a, ant_b;
  logic          buf_sel, last_triangle;
  logic          bl_valid;
  logic [BB-1:0] bl_idx;
  logic          bl_conj, bl_redundant, bl_buf, bl_frame_end, seq_err;
  logic [15:0]   err_cnt;

  bl_order_decode #(.N_ANTS(N)) dut (
    .clk(clk), .rst_n(rst_n), .sync(sync), .in_valid(in_valid),
    .ant_a(ant_a), .ant_b(ant_b), .buf_sel(buf_sel),
    .last_triangle(last_triangle), .bl_valid(bl_valid), .bl_idx(bl_idx),
    .bl_conj(bl_conj), .bl_redundant(bl_redundant), .bl_buf(bl_buf),
    .bl_frame_end(bl_frame_end), .seq_err(seq_err), .err_cnt(err_cnt)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int errors  = 0;
  bit mon_en  = 1'b1;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_exp, mon_got;

  // Independent index model: sum of row lengths above row lo, plus column.
  function automatic logic [BB-1:0] ref_idx(input int a, input int b);
    int lo, hi, s;
    lo = (a < b) ? a : b;
    hi = (a < b) ? b : a;
    s  = 0;
    for (int k = 0; k < lo; k++) s += N - k;
    s += hi - lo;
    return BB'(s);
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    if (mon_en && bl_valid) begin
      vectors++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: bl_valid=1 idx=%0d at cycle %0d, none required", bl_idx, cyc);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_got = {cyc, bl_idx, bl_conj, bl_redundant, bl_buf, bl_frame_end};
        if (mon_got !== mon_exp) begin
          errors++;
          $display("FAIL output: got cyc=%0d idx=%0d c/r/b/f=%b required cyc=%0d idx=%0d c/r/b/f=%b",
                   mon_got[W-1 -: 32], mon_got[BB+3:4], mon_got[3:0],
                   mon_exp[W-1 -: 32], mon_exp[BB+3:4], mon_exp[3:0]);
        end
      end
    end
  end

  // driver tasks
  task automatic drive_pair(input int a, input int b, input logic bs,
                            input logic do_sync, input logic [BB-1:0] idx,
                            input logic conj, input logic red, input logic fe);
    sync          = do_sync;
    in_valid      = 1'b1;
    ant_a         = AB'(a);
    ant_b         = AB'(b);
    buf_sel       = bs;
    last_triangle = (a > b);
    exp_q.push_back({cyc + 32'd3, idx, conj, red, bs, fe});
    @(posedge clk); #1;
    sync     = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_sync();
    sync = 1'b1;
    @(posedge clk); #1;
    sync = 1'b0;
  endtask

  // One generator frame: column eb runs ea = eb+N/2 .. eb (mod N).
  task automatic drive_frame(input logic parity, input bit gapped, input bit sync_first,
                             input bit corrupt01);
    int ea, eb2;
    logic lower;
    bit first;
    first = sync_first;
    for (int eb = 0; eb < N; eb++) begin
      for (int k = 0; k <= N/2; k++) begin
        ea    = (eb + N/2 + k) % N;
        lower = (ea > eb);
        eb2   = eb;
        if (corrupt01 && ea == 0 && eb == 1) eb2 = 2;
        drive_pair(ea, eb2, parity ^ lower, first, ref_idx(ea, eb2),
                   (ea > eb2), (ea > eb2) && (ea - eb2 == N/2),
                   (ea == N-1) && (eb == N-1));
        first = 1'b0;
        if (gapped) idle(1);
      end
    end
  endtask

  task automatic check_drained(input string name);
    idle(5);
    vectors++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d outputs outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_status(input string name, input logic e_err, input logic [15:0] e_cnt);
    vectors++;
    if (seq_err !== e_err) begin
      errors++;
      $display("FAIL %s_seq_err: got %b required %b", name, seq_err, e_err);
    end
    vectors++;
    if (err_cnt !== e_cnt) begin
      errors++;
      $display("FAIL %s_err_cnt: got %0d required %0d", name, err_cnt, e_cnt);
    end
  endtask

  // tests
  task automatic test_reset();
    rst_n = 1'b0; sync = 1'b0; in_valid = 1'b0; ant_a = '0; ant_b = '0;
    buf_sel = 1'b0; last_triangle = 1'b0;
    idle(3);
    vectors++;
    if ({bl_valid, bl_idx, bl_conj, bl_redundant, bl_buf, bl_frame_end, seq_err, err_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b idx=%0d flags=%b%b%b%b err=%b cnt=%0d required all 0",
               bl_valid, bl_idx, bl_conj, bl_redundant, bl_buf, bl_frame_end, seq_err, err_cnt);
    end
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_sequence();
    int tbl [12] = '{2, 3, 0, 6, 1, 4, 2, 5, 7, 6, 8, 9};
    logic [11:0] conj_m = 12'b0000_0000_1011; // bit i = pair i+1
    logic [11:0] red_m  = 12'b0000_0000_1001;
    int i, ea;
    pulse_sync();
    i = 0;
    for (int eb = 0; eb < N; eb++)
      for (int k = 0; k <= N/2; k++) begin
        ea = (eb + N/2 + k) % N;
        drive_pair(ea, eb, (ea > eb), 1'b0, BB'(tbl[i]), conj_m[i], red_m[i], (i == 11));
        i++;
      end
    check_drained("sequence");
    check_status("sequence", 1'b0, 16'd0);
  endtask

  task automatic test_gapped();
    pulse_sync();
    drive_frame(1'b0, 1'b1, 1'b0, 1'b0);
    check_drained("gapped");
    check_status("gapped", 1'b0, 16'd0);
  endtask

  task automatic test_back_to_back();
    // sync arrives together with the first pair
    drive_frame(1'b0, 1'b0, 1'b1, 1'b0);
    drive_frame(1'b1, 1'b0, 1'b0, 1'b0);
    drive_frame(1'b0, 1'b0, 1'b0, 1'b0);
    check_drained("back_to_back");
    check_status("back_to_back", 1'b0, 16'd0);
  endtask

  task automatic test_corrupt();
    pulse_sync();
    drive_frame(1'b0, 1'b0, 1'b0, 1'b1);
    drive_frame(1'b1, 1'b0, 1'b0, 1'b0);
    check_drained("corrupt");
    check_status("corrupt", 1'b1, 16'd1);
    pulse_sync();
    check_status("corrupt_sync", 1'b0, 16'd0);
  endtask

  task automatic test_reset_midframe();
    pulse_sync();
    sync = 1'b1; in_valid = 1'b1; ant_a = 2'd2; ant_b = 2'd0;
    buf_sel = 1'b1; last_triangle = 1'b1;
    @(posedge clk); #1;
    sync = 1'b0; ant_a = 2'd3;
    @(posedge clk); #1;
    ant_a = 2'd0; buf_sel = 1'b0; last_triangle = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    // three pairs now occupy the pipeline; kill it away from any edge
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({bl_valid, bl_idx, bl_conj, bl_redundant, bl_buf, bl_frame_end, seq_err, err_cnt} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: got v=%b idx=%0d flags=%b%b%b%b err=%b cnt=%0d required all 0",
               bl_valid, bl_idx, bl_conj, bl_redundant, bl_buf, bl_frame_end, seq_err, err_cnt);
    end
    idle(2);
    rst_n = 1'b1;
    idle(4);
    pulse_sync();
    drive_pair(2, 0, 1'b1, 1'b0, BB'(2), 1'b1, 1'b1, 1'b0);
    check_drained("midreset");
    check_status("midreset", 1'b0, 16'd0);
  endtask

  task automatic test_saturate();
    pulse_sync();
    mon_en = 1'b0;
    // (0,1) tagged as lower-triangle can never match the expected pair
    in_valid = 1'b1; ant_a = 2'd0; ant_b = 2'd1; buf_sel = 1'b0; last_triangle = 1'b1;
    repeat (65534) @(posedge clk);
    #1;
    check_status("saturate_pre", 1'b1, 16'd65534);
    repeat (70000 - 65534) @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_status("saturate", 1'b1, 16'hFFFF);
    idle(5);
    mon_en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_gapped();
    test_back_to_back();
    test_corrupt();
    test_reset_midframe();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
